// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: raster read-address generator, RAM-latency-aligned sync pipeline and vsync-edge buffer swap
module fb_scanout_reader #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  de_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  disp_buf,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata0,
  input  logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] pix_out,
  output logic                  de_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  disp_valid,
  output logic                  addr_err
);
  localparam int N = H_ACTIVE * V_ACTIVE;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state;
  logic vs_q, vs_rise, wrapped, last;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [RAM_LATENCY-1:0] de_p, hs_p, vs_p, sel_p;
  assign vs_rise   = vsync_in & ~vs_q;
  assign last      = addr_cnt == ADDR_WIDTH'(N - 1);
  assign raddr     = de_in ? addr_cnt : '0;
  // Ack is tied to the edge cycle itself; a reset in that cycle cancels the pending swap
  assign swap_ack  = ~reset & (state == PENDING) & vs_rise;
  assign de_out    = de_p[RAM_LATENCY-1];
  assign hsync_out = hs_p[RAM_LATENCY-1];
  assign vsync_out = vs_p[RAM_LATENCY-1];
  assign pix_out   = (de_out & disp_valid) ? (sel_p[RAM_LATENCY-1] ? rdata1 : rdata0) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q       <= 1'b1;
      addr_cnt   <= '0;
      wrapped    <= 1'b0;
      addr_err   <= 1'b0;
      state      <= IDLE;
      disp_buf   <= 1'b0;
      disp_valid <= 1'b0;
      de_p       <= '0;
      hs_p       <= '1;
      vs_p       <= '1;
      sel_p      <= '0;
    end else begin
      vs_q <= vsync_in;
      if (vs_rise) begin
        addr_cnt <= '0;
        wrapped  <= 1'b0;
      end else if (de_in) begin
        addr_cnt <= last ? '0 : addr_cnt + ADDR_WIDTH'(1);
        if (last) wrapped <= 1'b1;
        if (wrapped && addr_cnt == '0) addr_err <= 1'b1;
      end
      de_p[0]  <= de_in;
      hs_p[0]  <= hsync_in;
      vs_p[0]  <= vsync_in;
      sel_p[0] <= disp_buf;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        de_p[i]  <= de_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
        sel_p[i] <= sel_p[i-1];
      end
      if (state == IDLE) begin
        if (swap_req) state <= PENDING;
      end else if (vs_rise) begin
        state      <= IDLE;
        disp_buf   <= ~disp_buf;
        disp_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb_fb_scanout_reader: directed checks on a shrunken 8x4 raster (12x7 total) with latency-1 and latency-2 instances
module tb_fb_scanout_reader;
  localparam int H = 8, V = 4, HT = 12, VT = 7, AW = 6, DW = 8;
  logic clk = 0, reset = 1, de_in = 0, hsync_in = 1, vsync_in = 1, swap_req = 0;
  logic swap_ack1, disp_buf1, disp_valid1, addr_err1, de_out1, hsync_out1, vsync_out1;
  logic swap_ack2, disp_buf2, disp_valid2, addr_err2, de_out2, hsync_out2, vsync_out2;
  logic [AW-1:0] raddr1, raddr2;
  logic [DW-1:0] rdata0_1, rdata1_1, pix_out1, rdata0_2, rdata1_2, pix_out2, q0, q1;
  int hc = 11, vc = 6, h1 = 11, v1 = 6, h2 = 11, v2 = 6;
  int n_chk = 0, n_fail = 0;
  logic e_buf = 0;
  always #5 clk = ~clk;
  fb_scanout_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .swap_req(swap_req), .swap_ack(swap_ack1), .disp_buf(disp_buf1), .raddr(raddr1),
    .rdata0(rdata0_1), .rdata1(rdata1_1), .pix_out(pix_out1), .de_out(de_out1),
    .hsync_out(hsync_out1), .vsync_out(vsync_out1), .disp_valid(disp_valid1), .addr_err(addr_err1));
  fb_scanout_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .swap_req(swap_req), .swap_ack(swap_ack2), .disp_buf(disp_buf2), .raddr(raddr2),
    .rdata0(rdata0_2), .rdata1(rdata1_2), .pix_out(pix_out2), .de_out(de_out2),
    .hsync_out(hsync_out2), .vsync_out(vsync_out2), .disp_valid(disp_valid2), .addr_err(addr_err2));
  // fb0 holds addr[7:0], fb1 holds addr[7:0]+0x80
  always @(posedge clk) begin
    rdata0_1 <= DW'(raddr1);
    rdata1_1 <= DW'(raddr1) + 8'h80;
    q0 <= DW'(raddr2);
    q1 <= DW'(raddr2) + 8'h80;
    rdata0_2 <= q0;
    rdata1_2 <= q1;
  end
  function automatic logic de_of(int h, int v); return h < H && v < V; endfunction
  function automatic logic hs_of(int h); return !(h == 9 || h == 10); endfunction
  function automatic logic vs_of(int v); return v != 5; endfunction
  function automatic logic [AW-1:0] ra_of(int h, int v); return de_of(h, v) ? AW'(v * H + h) : '0; endfunction
  function automatic logic [DW-1:0] pix_of(int h, int v, logic b);
    return de_of(h, v) ? (b ? DW'(v * H + h + 128) : DW'(v * H + h)) : '0;
  endfunction
  task automatic drive();
    de_in = de_of(hc, vc);
    hsync_in = hs_of(hc);
    vsync_in = vs_of(vc);
  endtask
  task automatic cyc();
    @(posedge clk); #1;
    swap_req = 0;
    h2 = h1; v2 = v1; h1 = hc; v1 = vc;
    if (hc == HT - 1) begin hc = 0; vc = (vc == VT - 1) ? 0 : vc + 1; end else hc = hc + 1;
    drive();
    @(negedge clk);
  endtask
  task automatic test_reset();
    n_chk++; if (raddr1 !== '0 || raddr2 !== '0) begin n_fail++; $display("FAIL reset_raddr got %0d/%0d exp 0", raddr1, raddr2); end
    n_chk++; if ({swap_ack1, disp_buf1, disp_valid1, addr_err1, de_out1, hsync_out1, vsync_out1} !== 7'b0000011) begin
      n_fail++; $display("FAIL reset_ctl1 got %b exp 0000011", {swap_ack1, disp_buf1, disp_valid1, addr_err1, de_out1, hsync_out1, vsync_out1}); end
    n_chk++; if ({swap_ack2, disp_buf2, disp_valid2, addr_err2, de_out2, hsync_out2, vsync_out2} !== 7'b0000011) begin
      n_fail++; $display("FAIL reset_ctl2 got %b exp 0000011", {swap_ack2, disp_buf2, disp_valid2, addr_err2, de_out2, hsync_out2, vsync_out2}); end
    n_chk++; if (pix_out1 !== '0 || pix_out2 !== '0) begin n_fail++; $display("FAIL reset_pix got %h/%h exp 0", pix_out1, pix_out2); end
  endtask
  task automatic test_no_swap();
    for (int c = 0; c < HT * VT; c++) begin
      cyc();
      n_chk++; if (raddr1 !== ra_of(hc, vc) || raddr2 !== ra_of(hc, vc)) begin
        n_fail++; $display("FAIL raddr at %0d,%0d got %0d/%0d exp %0d", hc, vc, raddr1, raddr2, ra_of(hc, vc)); end
      n_chk++; if ({de_out1, hsync_out1, vsync_out1} !== {de_of(h1, v1), hs_of(h1), vs_of(v1)}) begin
        n_fail++; $display("FAIL sync_lat1 at %0d,%0d got %b exp %b", hc, vc, {de_out1, hsync_out1, vsync_out1}, {de_of(h1, v1), hs_of(h1), vs_of(v1)}); end
      n_chk++; if ({de_out2, hsync_out2, vsync_out2} !== {de_of(h2, v2), hs_of(h2), vs_of(v2)}) begin
        n_fail++; $display("FAIL sync_lat2 at %0d,%0d got %b exp %b", hc, vc, {de_out2, hsync_out2, vsync_out2}, {de_of(h2, v2), hs_of(h2), vs_of(v2)}); end
      n_chk++; if ({pix_out1, pix_out2} !== '0 || {disp_valid1, disp_valid2, addr_err1, addr_err2, swap_ack1, swap_ack2} !== '0) begin
        n_fail++; $display("FAIL idle_out at %0d,%0d pix %h/%h flags %b exp 0", hc, vc, pix_out1, pix_out2,
          {disp_valid1, disp_valid2, addr_err1, addr_err2, swap_ack1, swap_ack2}); end
    end
  endtask
  task automatic test_swap();
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < HT * VT; c++) begin
        cyc();
        if (f < 2 && hc == 0 && vc == 2) swap_req = 1;
        n_chk++; if (swap_ack1 !== (f < 2 && hc == 0 && vc == 6) || swap_ack2 !== swap_ack1) begin
          n_fail++; $display("FAIL swap_ack f%0d at %0d,%0d got %b/%b", f, hc, vc, swap_ack1, swap_ack2); end
        if (f > 0) begin
          n_chk++; if (pix_out1 !== pix_of(h1, v1, e_buf) || pix_out2 !== pix_of(h2, v2, e_buf)) begin
            n_fail++; $display("FAIL swap_pix f%0d at %0d,%0d got %h/%h exp %h/%h", f, hc, vc, pix_out1, pix_out2,
              pix_of(h1, v1, e_buf), pix_of(h2, v2, e_buf)); end
        end
      end
      if (f < 2) e_buf = ~e_buf;
      n_chk++; if (disp_buf1 !== e_buf || disp_buf2 !== e_buf || disp_valid1 !== 1'b1 || disp_valid2 !== 1'b1) begin
        n_fail++; $display("FAIL swap_state f%0d buf %b/%b valid %b/%b exp buf %b valid 1", f, disp_buf1, disp_buf2, disp_valid1, disp_valid2, e_buf); end
    end
  endtask
  task automatic test_swap_at_rise();
    int acks;
    for (int f = 0; f < 2; f++) begin
      acks = 0;
      for (int c = 0; c < HT * VT; c++) begin
        cyc();
        if (f == 0 && hc == 0 && vc == 6) swap_req = 1;
        if (swap_ack1) acks++;
        if (swap_ack2) acks++;
        if (hc == 0 && vc == 6) begin
          n_chk++; if (swap_ack1 !== (f == 1) || swap_ack2 !== (f == 1)) begin
            n_fail++; $display("FAIL rise_ack f%0d got %b/%b exp %b", f, swap_ack1, swap_ack2, f == 1); end
        end
      end
      if (f == 1) e_buf = ~e_buf;
      n_chk++; if (acks !== 2 * f || disp_buf1 !== e_buf || disp_buf2 !== e_buf) begin
        n_fail++; $display("FAIL rise_frame f%0d acks %0d buf %b/%b exp acks %0d buf %b", f, acks, disp_buf1, disp_buf2, 2 * f, e_buf); end
    end
  endtask
  task automatic test_multi_req();
    int acks1 = 0, acks2 = 0;
    for (int c = 0; c < HT * VT; c++) begin
      cyc();
      if ((hc == 0 && vc == 1) || (hc == 0 && vc == 2) || (hc == 3 && vc == 3)) swap_req = 1;
      if (swap_ack1) acks1++;
      if (swap_ack2) acks2++;
    end
    e_buf = ~e_buf;
    n_chk++; if (acks1 !== 1 || acks2 !== 1) begin n_fail++; $display("FAIL multi_acks got %0d/%0d exp 1", acks1, acks2); end
    n_chk++; if (disp_buf1 !== e_buf || disp_buf2 !== e_buf) begin n_fail++; $display("FAIL multi_buf got %b/%b exp %b", disp_buf1, disp_buf2, e_buf); end
  endtask
  task automatic test_latency2();
    for (int c = 0; c < HT * VT; c++) begin
      cyc();
      if (h2 == 0 && v2 < V) begin
        n_chk++; if (pix_out2 !== pix_of(0, v2, e_buf) || de_out2 !== 1'b1) begin
          n_fail++; $display("FAIL lat2_line_start y%0d got %h de %b exp %h de 1", v2, pix_out2, de_out2, pix_of(0, v2, e_buf)); end
      end
      if (h1 == 0 && v1 < V) begin
        n_chk++; if (pix_out1 !== pix_of(0, v1, e_buf)) begin
          n_fail++; $display("FAIL lat1_line_start y%0d got %h exp %h", v1, pix_out1, pix_of(0, v1, e_buf)); end
      end
    end
  endtask
  task automatic test_overflow_reset();
    int err_drop = 0;
    for (int i = 0; i <= H * V; i++) begin
      @(posedge clk); #1;
      de_in = 1; hsync_in = 1; vsync_in = 1;
      #3;
      n_chk++; if (raddr1 !== AW'(i % (H * V)) || raddr2 !== AW'(i % (H * V)) || addr_err1 !== 1'b0) begin
        n_fail++; $display("FAIL ovf_cnt i%0d raddr %0d/%0d err %b exp %0d err 0", i, raddr1, raddr2, addr_err1, i % (H * V)); end
    end
    @(posedge clk); #1;
    de_in = 0;
    #3;
    n_chk++; if (addr_err1 !== 1'b1 || addr_err2 !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b/%b exp 1", addr_err1, addr_err2); end
    repeat (5) begin
      @(posedge clk); #1;
      if (addr_err1 !== 1'b1 || addr_err2 !== 1'b1) err_drop++;
    end
    n_chk++; if (err_drop !== 0) begin n_fail++; $display("FAIL ovf_sticky dropped %0d times exp 0", err_drop); end
    swap_req = 1;
    @(posedge clk); #1;
    swap_req = 0; vsync_in = 0;
    @(posedge clk); #1;
    vsync_in = 1; reset = 1;
    #3;
    n_chk++; if (swap_ack1 !== 1'b0 || swap_ack2 !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b/%b exp 0", swap_ack1, swap_ack2); end
    @(posedge clk); #1;
    reset = 0;
    n_chk++; if ({swap_ack1, disp_buf1, disp_valid1, addr_err1, de_out1, hsync_out1, vsync_out1} !== 7'b0000011 || raddr1 !== '0 || pix_out1 !== '0) begin
      n_fail++; $display("FAIL rst_mid1 got %b raddr %0d pix %h exp 0000011", {swap_ack1, disp_buf1, disp_valid1, addr_err1, de_out1, hsync_out1, vsync_out1}, raddr1, pix_out1); end
    n_chk++; if ({swap_ack2, disp_buf2, disp_valid2, addr_err2, de_out2, hsync_out2, vsync_out2} !== 7'b0000011 || raddr2 !== '0 || pix_out2 !== '0) begin
      n_fail++; $display("FAIL rst_mid2 got %b raddr %0d pix %h exp 0000011", {swap_ack2, disp_buf2, disp_valid2, addr_err2, de_out2, hsync_out2, vsync_out2}, raddr2, pix_out2); end
    err_drop = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (swap_ack1 || swap_ack2 || disp_buf1 || disp_buf2) err_drop++;
    end
    n_chk++; if (err_drop !== 0) begin n_fail++; $display("FAIL rst_no_swap saw %0d ack/buf cycles exp 0", err_drop); end
  endtask
  initial begin
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    test_no_swap();
    test_swap();
    test_latency2();
    test_swap_at_rise();
    test_multi_req();
    test_overflow_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
